bcd_stopwatch: RTL and testbench

- Downstream consumer of the periodic tick divider (the CLK_RATE/DIV_FACTOR count-up stage).
- Takes that stage's one-cycle tick strobe and accumulates elapsed ticks as a multi-digit BCD count.
- Controlled by start/stop, clear and lap command pulses.
- Drives a seven-segment display driver directly through digits_o.

---
 rtl/bcd_stopwatch.sv | 146 ++++++++++++++
 tb/tb_bcd_stopwatch.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: accumulates one-cycle tick strobes as a NUM_DIGITS-digit
// BCD count under start/stop, clear and lap command pulses.
// Optional lap-hold display freeze is built when LAP_HOLD_EN is defined;
// otherwise lap_i is ignored and no lap register or LAP state exists.
module bcd_stopwatch #(
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    tick_i,
   input  logic                    start_stop_i,
   input  logic                    clear_i,
   input  logic                    lap_i,
   output logic [4*NUM_DIGITS-1:0] digits_o,
   output logic                    running_o,
   output logic                    overflow_o
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUNNING = 2'd1;
   localparam logic [1:0] ST_PAUSED  = 2'd2;
   localparam logic [1:0] ST_LAP     = 2'd3;

   logic [1:0]              state_q, state_d;
   logic [4*NUM_DIGITS-1:0] count_q, count_d;
   logic [4*NUM_DIGITS-1:0] count_inc;
   logic                    wrap;
   logic                    ovf_q, ovf_d;
   logic                    counting;

   // BCD ripple increment of the live count; wrap flags the all-9s rollover
   always_comb begin
      logic carry;
      count_inc = count_q;
      carry     = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            // >= 9 also folds any corrupted digit back to a legal value
            if (count_q[4*i +: 4] >= 4'd9) begin
               count_inc[4*i +: 4] = '0;
            end else begin
               count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
      wrap = carry;
   end

`ifdef LAP_HOLD_EN
   logic [4*NUM_DIGITS-1:0] lap_q, lap_d;

   assign counting = tick_i && ((state_q == ST_RUNNING) || (state_q == ST_LAP));
`else
   logic unused_lap;

   assign unused_lap = lap_i;
   assign counting   = tick_i && (state_q == ST_RUNNING);
`endif

   // Next-state, count and overflow decode; clear outranks start/stop outranks lap
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ovf_d   = ovf_q;
`ifdef LAP_HOLD_EN
      lap_d   = lap_q;
`endif
      if (clear_i) begin
         state_d = ST_IDLE;
         count_d = '0;
         ovf_d   = 1'b0;
`ifdef LAP_HOLD_EN
         lap_d   = '0;
`endif
      end else begin
         if (counting) begin
            count_d = count_inc;
            if (wrap) begin
               ovf_d = 1'b1;
            end
         end
         case (state_q)
            ST_IDLE: begin
               if (start_stop_i) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
               if (start_stop_i) begin
                  state_d = ST_PAUSED;
`ifdef LAP_HOLD_EN
               end else if (lap_i) begin
                  lap_d   = count_q;
                  state_d = ST_LAP;
`endif
               end
            end
            ST_PAUSED: begin
               if (start_stop_i) state_d = ST_RUNNING;
            end
`ifdef LAP_HOLD_EN
            ST_LAP: begin
               if (start_stop_i) begin
                  state_d = ST_PAUSED;
               end else if (lap_i) begin
                  state_d = ST_RUNNING;
               end
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State, count and sticky overflow registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef LAP_HOLD_EN
   // Lap capture register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_q <= '0;
      end else begin
         lap_q <= lap_d;
      end
   end

   assign digits_o  = (state_q == ST_LAP) ? lap_q : count_q;
   assign running_o = (state_q == ST_RUNNING) || (state_q == ST_LAP);
`else
   assign digits_o  = count_q;
   assign running_o = (state_q == ST_RUNNING);
`endif

   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: directed scenarios plus random
// command/tick traffic compared against an integer-valued stopwatch model.
module tb_bcd_stopwatch;

   localparam int ND  = 4;
   localparam int MOD = 10000;

   logic          clk;
   logic          rst_n;
   logic          tick_i, start_stop_i, clear_i, lap_i;
   logic [4*ND-1:0] digits_o;
   logic          running_o, overflow_o;

   int checks;
   int errors;

   // model: 0 idle, 1 running, 2 paused, 3 lap
   int m_state;
   int m_count;
   int m_lap;
   bit m_ovf;

   bcd_stopwatch #(.NUM_DIGITS(ND)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick_i       (tick_i),
      .start_stop_i (start_stop_i),
      .clear_i      (clear_i),
      .lap_i        (lap_i),
      .digits_o     (digits_o),
      .running_o    (running_o),
      .overflow_o   (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4*ND-1:0] to_bcd(input int v);
      logic [4*ND-1:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [4*ND-1:0] exp_digits();
      return to_bcd((m_state == 3) ? m_lap : m_count);
   endfunction

   function automatic logic exp_running();
      return (m_state == 1) || (m_state == 3);
   endfunction

   task automatic model_reset();
      m_state = 0; m_count = 0; m_lap = 0; m_ovf = 0;
   endtask

   // stopwatch rules applied to one clock edge's commands
   task automatic model_edge(input bit t, input bit ss, input bit cl, input bit lp);
      int old;
      old = m_count;
      if (cl) begin
         model_reset();
      end else begin
         if (t && (m_state == 1 || m_state == 3)) begin
            m_count = m_count + 1;
            if (m_count == MOD) begin
               m_count = 0;
               m_ovf   = 1;
            end
         end
         case (m_state)
            0: if (ss) m_state = 1;
            1: begin
               if (ss) m_state = 2;
`ifdef LAP_HOLD_EN
               else if (lp) begin m_lap = old; m_state = 3; end
`endif
            end
            2: if (ss) m_state = 1;
            3: begin
               if (ss) m_state = 2;
               else if (lp) m_state = 1;
            end
            default: m_state = 0;
         endcase
      end
   endtask

   // drive one cycle of commands, advance the model, sample 1 time unit after the edge
   task automatic step(input bit t, input bit ss, input bit cl, input bit lp);
      tick_i = t; start_stop_i = ss; clear_i = cl; lap_i = lp;
      @(posedge clk);
      model_edge(t, ss, cl, lp);
      #1;
      tick_i = 0; start_stop_i = 0; clear_i = 0; lap_i = 0;
   endtask

   task automatic goto_running(input int n);
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst_n = 0; tick_i = 0; start_stop_i = 0; clear_i = 0; lap_i = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      checks++;
      if (digits_o !== '0 || running_o !== 1'b0 || overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: digits=%h running=%b ovf=%b, expected 0000 0 0",
                  digits_o, running_o, overflow_o);
      end
   endtask

   task automatic test_count();
      step(0, 1, 0, 0);
      for (int k = 0; k < 12; k++) begin
         step(1, 0, 0, 0);
         checks++;
         if (digits_o !== exp_digits() || running_o !== 1'b1) begin
            errors++;
            $display("FAIL count_latency tick %0d: digits=%h running=%b, expected %h 1",
                     k, digits_o, running_o, exp_digits());
         end
         repeat (4) step(0, 0, 0, 0);
      end
      checks++;
      if (digits_o !== 16'h0012 || running_o !== 1'b1) begin
         errors++;
         $display("FAIL count_12: digits=%h running=%b, expected 0012 1", digits_o, running_o);
      end
   endtask

   task automatic test_wrap();
      goto_running(9999);
      checks++;
      if (digits_o !== 16'h9999 || overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL wrap_preload: digits=%h ovf=%b, expected 9999 0", digits_o, overflow_o);
      end
      step(1, 0, 0, 0);
      checks++;
      if (digits_o !== 16'h0000 || overflow_o !== 1'b1) begin
         errors++;
         $display("FAIL wrap_rollover: digits=%h ovf=%b, expected 0000 1", digits_o, overflow_o);
      end
      step(1, 0, 0, 0);
      checks++;
      if (digits_o !== 16'h0001 || overflow_o !== 1'b1) begin
         errors++;
         $display("FAIL wrap_continue: digits=%h ovf=%b, expected 0001 1", digits_o, overflow_o);
      end
      step(0, 0, 1, 0);
      checks++;
      if (digits_o !== 16'h0000 || overflow_o !== 1'b0 || running_o !== 1'b0) begin
         errors++;
         $display("FAIL wrap_clear: digits=%h ovf=%b running=%b, expected 0000 0 0",
                  digits_o, overflow_o, running_o);
      end
   endtask

   task automatic test_pause();
      goto_running(41);
      step(1, 1, 0, 0);
      checks++;
      if (digits_o !== 16'h0042 || running_o !== 1'b0) begin
         errors++;
         $display("FAIL pause_same_cycle_tick: digits=%h running=%b, expected 0042 0",
                  digits_o, running_o);
      end
      repeat (3) step(1, 0, 0, 0);
      checks++;
      if (digits_o !== 16'h0042) begin
         errors++;
         $display("FAIL pause_ignore_ticks: digits=%h, expected 0042", digits_o);
      end
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      checks++;
      if (digits_o !== 16'h0043 || running_o !== 1'b1) begin
         errors++;
         $display("FAIL pause_resume: digits=%h running=%b, expected 0043 1", digits_o, running_o);
      end
   endtask

   task automatic test_clear_priority();
      goto_running(7);
      step(1, 1, 1, 1);
      checks++;
      if (digits_o !== 16'h0000 || running_o !== 1'b0 || overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL clear_priority: digits=%h running=%b ovf=%b, expected 0000 0 0",
                  digits_o, running_o, overflow_o);
      end
      // idle after clear: tick alongside start is not counted, lap ignored
      step(1, 1, 0, 1);
      checks++;
      if (digits_o !== 16'h0000 || running_o !== 1'b1) begin
         errors++;
         $display("FAIL idle_start_tick: digits=%h running=%b, expected 0000 1", digits_o, running_o);
      end
   endtask

   task automatic test_lap();
      logic [4*ND-1:0] held;
      goto_running(25);
      step(0, 0, 0, 1);
      repeat (4) step(1, 0, 0, 0);
`ifdef LAP_HOLD_EN
      held = 16'h0025;
`else
      held = 16'h0029;
`endif
      checks++;
      if (digits_o !== held || running_o !== 1'b1) begin
         errors++;
         $display("FAIL lap_hold: digits=%h running=%b, expected %h 1", digits_o, running_o, held);
      end
      step(0, 0, 0, 1);
      checks++;
      if (digits_o !== 16'h0029 || running_o !== 1'b1) begin
         errors++;
         $display("FAIL lap_release: digits=%h running=%b, expected 0029 1", digits_o, running_o);
      end
   endtask

   task automatic test_async_reset();
      goto_running(330);
      checks++;
      if (digits_o !== 16'h0330) begin
         errors++;
         $display("FAIL areset_preload: digits=%h, expected 0330", digits_o);
      end
      #2;
      rst_n = 0;
      #1;
      model_reset();
      checks++;
      if (digits_o !== '0 || running_o !== 1'b0 || overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL areset_immediate: digits=%h running=%b ovf=%b, expected 0000 0 0",
                  digits_o, running_o, overflow_o);
      end
      @(posedge clk);
      #1;
      rst_n = 1;
      repeat (3) step(1, 0, 0, 0);
      checks++;
      if (digits_o !== '0 || running_o !== 1'b0) begin
         errors++;
         $display("FAIL areset_idle_ticks: digits=%h running=%b, expected 0000 0", digits_o, running_o);
      end
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      checks++;
      if (digits_o !== 16'h0001 || running_o !== 1'b1) begin
         errors++;
         $display("FAIL areset_restart: digits=%h running=%b, expected 0001 1", digits_o, running_o);
      end
   endtask

   task automatic test_random();
      bit t, ss, cl, lp;
      int errs_here;
      errs_here = 0;
      for (int n = 0; n < 3000; n++) begin
         t  = ($urandom_range(0, 99) < 60);
         ss = ($urandom_range(0, 99) < 6);
         cl = ($urandom_range(0, 999) < 8);
         lp = ($urandom_range(0, 99) < 6);
         step(t, ss, cl, lp);
         checks++;
         if (digits_o !== exp_digits() || running_o !== exp_running() || overflow_o !== m_ovf) begin
            errors++;
            errs_here++;
            if (errs_here <= 20)
               $display("FAIL random cycle %0d: digits=%h running=%b ovf=%b, expected %h %b %b",
                        n, digits_o, running_o, overflow_o, exp_digits(), exp_running(), m_ovf);
         end
      end
      // drive near the wrap boundary under random commands
      goto_running(9990);
      for (int n = 0; n < 200; n++) begin
         step(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 3), 1'b0,
              ($urandom_range(0, 99) < 5));
         checks++;
         if (digits_o !== exp_digits() || running_o !== exp_running() || overflow_o !== m_ovf) begin
            errors++;
            $display("FAIL random_wrap cycle %0d: digits=%h running=%b ovf=%b, expected %h %b %b",
                     n, digits_o, running_o, overflow_o, exp_digits(), exp_running(), m_ovf);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_count();
      test_wrap();
      test_pause();
      test_clear_priority();
      test_lap();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
